// File: rtl/dsp_out_seq_pkg.sv
// Shared constants, register offsets and bus-FSM encoding for the DSP output sequencer.
package dsp_out_seq_pkg;

  localparam int CH_W = 8;

  localparam logic [1:0] OFF_SET   = 2'd0;
  localparam logic [1:0] OFF_CLR   = 2'd1;
  localparam logic [1:0] OFF_PULSE = 2'd2;
  localparam logic [1:0] OFF_PLEN  = 2'd3;

  localparam logic [7:0] PULSE_LEN_RST = 8'd16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_HOLD = 2'd1,
    ST_RD_HOLD = 2'd2
  } bus_state_t;

  // A zero length would make the down-counter wrap, so it is stored as one clock.
  function automatic logic [7:0] norm_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/dsp_out_pulse_timer.sv
// Pulse down-counter: loads len on start, stays busy for len clocks; done marks the final clock.
module dsp_out_pulse_timer
  import dsp_out_seq_pkg::*;
(
  input  logic       clkDspIn,
  input  logic       dsp_reset,
  input  logic       start,
  input  logic [7:0] len,
  output logic       busy,
  output logic       done
);

  logic [7:0] r_cnt;
  logic       r_busy;

  // done is high during the cycle whose closing edge brings the count to zero.
  assign done = r_busy && (r_cnt == 8'd1);
  assign busy = r_busy;

  always_ff @(posedge clkDspIn or negedge dsp_reset) begin
    if (!dsp_reset) begin
      r_cnt  <= 8'd0;
      r_busy <= 1'b0;
    end else if (start && !r_busy) begin
      r_cnt  <= norm_len(len);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 8'd1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/dsp_output_sequencer.sv
// DSP bus-mapped output register with SET/CLR/readback and optional timed pulses.
// Pulse timer present only when DSP_OUT_PULSE_TIMER_EN is defined.
module dsp_output_sequencer
  import dsp_out_seq_pkg::*;
#(
  parameter logic [10:0] BASE_ADDR = 11'h100
) (
  input  logic            clkDspIn,
  input  logic            dsp_reset,
  input  logic            we_deb,
  input  logic            re_deb,
  input  logic [10:0]     ab_buf,
  input  logic [CH_W-1:0] db_in,
  output logic [CH_W-1:0] out_bits,
  output logic            busy,
  output logic [CH_W-1:0] db_out,
  output logic            db_oe
);

  // Bus handshake: an access fires once on the IDLE edge where its strobe is
  // sampled low; the FSM then holds until that strobe is sampled high again.
  bus_state_t      r_state;
  logic [CH_W-1:0] r_out_bits;
  logic [CH_W-1:0] r_db_out;
  logic            r_db_oe;

  logic [10:0]     w_off;
  logic            w_hit;
  logic [1:0]      w_reg;
  logic            w_wr_go;
  logic            w_rd_go;
  logic            w_busy;
  logic [CH_W-1:0] w_pulse_clr;
  logic [CH_W-1:0] w_pulse_set;
  logic [7:0]      w_plen_rd;
  logic [CH_W-1:0] w_out_next;
  logic [CH_W-1:0] w_rd_data;

  assign w_off   = ab_buf - BASE_ADDR;
  assign w_hit   = (w_off[10:2] == 9'd0);
  assign w_reg   = w_off[1:0];
  assign w_wr_go = (r_state == ST_IDLE) && !we_deb && w_hit;
  assign w_rd_go = (r_state == ST_IDLE) && we_deb && !re_deb && w_hit;

`ifdef DSP_OUT_PULSE_TIMER_EN
  logic [7:0]      r_pulse_len;
  logic [CH_W-1:0] r_pulse_mask;
  logic            w_start;
  logic            w_done;

  assign w_start = w_wr_go && (w_reg == OFF_PULSE) && !w_busy;

  always_ff @(posedge clkDspIn or negedge dsp_reset) begin
    if (!dsp_reset) begin
      r_pulse_len  <= PULSE_LEN_RST;
      r_pulse_mask <= '0;
    end else begin
      if (w_wr_go && (w_reg == OFF_PLEN)) r_pulse_len <= norm_len(db_in);
      if (w_start) r_pulse_mask <= db_in;
    end
  end

  dsp_out_pulse_timer u_pulse_timer (
    .clkDspIn  (clkDspIn),
    .dsp_reset (dsp_reset),
    .start     (w_start),
    .len       (r_pulse_len),
    .busy      (w_busy),
    .done      (w_done)
  );

  assign w_pulse_clr = w_done  ? r_pulse_mask : '0;
  assign w_pulse_set = w_start ? db_in        : '0;
  assign w_plen_rd   = r_pulse_len;
`else
  assign w_busy      = 1'b0;
  assign w_pulse_clr = '0;
  assign w_pulse_set = '0;
  assign w_plen_rd   = 8'd0;
`endif

  // Pulse-end clear is applied first so a coincident bus write wins per bit.
  always_comb begin
    w_out_next = r_out_bits & ~w_pulse_clr;
    if (w_wr_go) begin
      case (w_reg)
        OFF_SET:   w_out_next = w_out_next | db_in;
        OFF_CLR:   w_out_next = w_out_next & ~db_in;
        OFF_PULSE: w_out_next = w_out_next | w_pulse_set;
        default:   w_out_next = w_out_next;
      endcase
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (w_reg)
      OFF_SET:  w_rd_data = r_out_bits;
      OFF_PLEN: w_rd_data = w_plen_rd;
      default:  w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clkDspIn or negedge dsp_reset) begin
    if (!dsp_reset) begin
      r_state    <= ST_IDLE;
      r_out_bits <= '0;
      r_db_out   <= '0;
      r_db_oe    <= 1'b0;
    end else begin
      r_out_bits <= w_out_next;
      case (r_state)
        ST_IDLE: begin
          if (w_wr_go) begin
            r_state <= ST_WR_HOLD;
          end else if (w_rd_go) begin
            r_state  <= ST_RD_HOLD;
            r_db_out <= w_rd_data;
            r_db_oe  <= 1'b1;
          end
        end
        ST_WR_HOLD: begin
          if (we_deb) r_state <= ST_IDLE;
        end
        ST_RD_HOLD: begin
          if (re_deb) begin
            r_state <= ST_IDLE;
            r_db_oe <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_db_oe <= 1'b0;
        end
      endcase
    end
  end

  assign out_bits = r_out_bits;
  assign busy     = w_busy;
  assign db_out   = r_db_out;
  assign db_oe    = r_db_oe;

endmodule

// File: tb/tb_dsp_output_sequencer.sv
// Directed bench for dsp_output_sequencer; pulse checks follow DSP_OUT_PULSE_TIMER_EN.
`timescale 1ns/1ps
module tb_dsp_output_sequencer;

  logic        clkDspIn;
  logic        dsp_reset;
  logic        we_deb;
  logic        re_deb;
  logic [10:0] ab_buf;
  logic [7:0]  db_in;
  logic [7:0]  out_bits;
  logic        busy;
  logic [7:0]  db_out;
  logic        db_oe;

  int tests;
  int fails;

  dsp_output_sequencer #(.BASE_ADDR(11'h100)) dut (
    .clkDspIn  (clkDspIn),
    .dsp_reset (dsp_reset),
    .we_deb    (we_deb),
    .re_deb    (re_deb),
    .ab_buf    (ab_buf),
    .db_in     (db_in),
    .out_bits  (out_bits),
    .busy      (busy),
    .db_out    (db_out),
    .db_oe     (db_oe)
  );

  initial clkDspIn = 1'b0;
  always #5 clkDspIn = ~clkDspIn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [10:0] a, input logic [7:0] d);
    @(negedge clkDspIn);
    ab_buf = a; db_in = d; we_deb = 1'b0;
    @(negedge clkDspIn);
    we_deb = 1'b1;
    @(negedge clkDspIn);
  endtask

  task automatic bus_read(input logic [10:0] a, input logic [7:0] exp, input string tag);
    @(negedge clkDspIn);
    ab_buf = a; re_deb = 1'b0;
    @(negedge clkDspIn);
    chk({tag, "_oe"}, {31'd0, db_oe}, 32'd1);
    chk({tag, "_data"}, {24'd0, db_out}, {24'd0, exp});
    re_deb = 1'b1;
    @(negedge clkDspIn);
    chk({tag, "_oe_off"}, {31'd0, db_oe}, 32'd0);
  endtask

  initial begin
    tests = 0; fails = 0;
    dsp_reset = 1'b0; we_deb = 1'b1; re_deb = 1'b1; ab_buf = 11'h000; db_in = 8'h00;

    repeat (2) @(negedge clkDspIn);
    chk("rst_out", {24'd0, out_bits}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dbout", {24'd0, db_out}, 32'h00);
    chk("rst_oe", {31'd0, db_oe}, 32'd0);
    dsp_reset = 1'b1;
    @(negedge clkDspIn);

    // SET 05 then CLR 04, each checked one clock after its strobe
    ab_buf = 11'h100; db_in = 8'h05; we_deb = 1'b0;
    @(negedge clkDspIn);
    chk("set05", {24'd0, out_bits}, 32'h05);
    we_deb = 1'b1;
    @(negedge clkDspIn);
    ab_buf = 11'h101; db_in = 8'h04; we_deb = 1'b0;
    @(negedge clkDspIn);
    chk("clr04", {24'd0, out_bits}, 32'h01);
    we_deb = 1'b1;
    @(negedge clkDspIn);
    bus_read(11'h100, 8'h01, "rd_set");

    // held SET strobe: changing data mid-hold must not fire again
    bus_write(11'h101, 8'hFF);
    chk("clr_all", {24'd0, out_bits}, 32'h00);
    @(negedge clkDspIn);
    ab_buf = 11'h100; db_in = 8'h80; we_deb = 1'b0;
    repeat (10) @(negedge clkDspIn);
    db_in = 8'h40;
    repeat (10) @(negedge clkDspIn);
    chk("held_set", {24'd0, out_bits}, 32'h80);
    we_deb = 1'b1;
    @(negedge clkDspIn);
    bus_write(11'h101, 8'h80);
    chk("held_then_clr", {24'd0, out_bits}, 32'h00);
    bus_write(11'h100, 8'h80);
    chk("second_set", {24'd0, out_bits}, 32'h80);

    // accesses outside the window
    bus_write(11'h104, 8'hFF);
    chk("oow_hi", {24'd0, out_bits}, 32'h80);
    bus_write(11'h0FF, 8'hFF);
    chk("oow_lo", {24'd0, out_bits}, 32'h80);
    @(negedge clkDspIn);
    ab_buf = 11'h105; re_deb = 1'b0;
    @(negedge clkDspIn);
    chk("oow_rd_oe", {31'd0, db_oe}, 32'd0);
    re_deb = 1'b1;

    // both strobes low: write wins, no read drive
    @(negedge clkDspIn);
    ab_buf = 11'h100; db_in = 8'h02; we_deb = 1'b0; re_deb = 1'b0;
    @(negedge clkDspIn);
    chk("both_out", {24'd0, out_bits}, 32'h82);
    chk("both_oe", {31'd0, db_oe}, 32'd0);
    @(negedge clkDspIn);
    chk("both_oe_hold", {31'd0, db_oe}, 32'd0);
    we_deb = 1'b1; re_deb = 1'b1;
    @(negedge clkDspIn);

`ifdef DSP_OUT_PULSE_TIMER_EN
    bus_read(11'h103, 8'd16, "plen_rst");
    bus_write(11'h103, 8'd3);
    bus_read(11'h103, 8'd3, "plen3");

    // mask 30 for 3 clocks; a second PULSE while busy is ignored
    @(negedge clkDspIn);
    ab_buf = 11'h102; db_in = 8'h30; we_deb = 1'b0;
    @(negedge clkDspIn);
    chk("pulse_c1_out", {24'd0, out_bits}, 32'hB2);
    chk("pulse_c1_busy", {31'd0, busy}, 32'd1);
    we_deb = 1'b1;
    @(negedge clkDspIn);
    chk("pulse_c2_out", {24'd0, out_bits}, 32'hB2);
    chk("pulse_c2_busy", {31'd0, busy}, 32'd1);
    db_in = 8'h03; we_deb = 1'b0;
    @(negedge clkDspIn);
    chk("pulse_c3_out", {24'd0, out_bits}, 32'hB2);
    chk("pulse_c3_busy", {31'd0, busy}, 32'd1);
    we_deb = 1'b1;
    @(negedge clkDspIn);
    chk("pulse_end_out", {24'd0, out_bits}, 32'h82);
    chk("pulse_end_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clkDspIn);
    chk("pulse_ignored", {24'd0, out_bits}, 32'h82);
    chk("pulse_ignored_busy", {31'd0, busy}, 32'd0);

    // zero length stores 1; mask 0 still runs the timer
    bus_write(11'h103, 8'd0);
    bus_read(11'h103, 8'd1, "plen0");
    @(negedge clkDspIn);
    ab_buf = 11'h102; db_in = 8'h00; we_deb = 1'b0;
    @(negedge clkDspIn);
    chk("mask0_busy", {31'd0, busy}, 32'd1);
    chk("mask0_out", {24'd0, out_bits}, 32'h82);
    we_deb = 1'b1;
    @(negedge clkDspIn);
    chk("mask0_done", {31'd0, busy}, 32'd0);

    // SET on the pulse-end clock keeps the bit high
    bus_write(11'h103, 8'd3);
    @(negedge clkDspIn);
    ab_buf = 11'h102; db_in = 8'h01; we_deb = 1'b0;
    @(negedge clkDspIn);
    we_deb = 1'b1;
    @(negedge clkDspIn);
    ab_buf = 11'h100;
    @(negedge clkDspIn);
    chk("coin_pre_busy", {31'd0, busy}, 32'd1);
    chk("coin_pre_out", {24'd0, out_bits}, 32'h83);
    we_deb = 1'b0;
    @(negedge clkDspIn);
    chk("coin_out", {24'd0, out_bits}, 32'h83);
    chk("coin_busy", {31'd0, busy}, 32'd0);
    we_deb = 1'b1;
    @(negedge clkDspIn);

    // reset at pulse clock 2 of a 16-clock pulse
    bus_write(11'h103, 8'd16);
    @(negedge clkDspIn);
    ab_buf = 11'h102; db_in = 8'hFF; we_deb = 1'b0;
    @(negedge clkDspIn);
    we_deb = 1'b1;
    @(negedge clkDspIn);
    chk("rp_pre_out", {24'd0, out_bits}, 32'hFF);
    dsp_reset = 1'b0;
    #1;
    chk("rp_out", {24'd0, out_bits}, 32'h00);
    chk("rp_busy", {31'd0, busy}, 32'd0);
    chk("rp_oe", {31'd0, db_oe}, 32'd0);
    @(negedge clkDspIn);
    dsp_reset = 1'b1;
    repeat (20) @(negedge clkDspIn);
    chk("rp_after_out", {24'd0, out_bits}, 32'h00);
    chk("rp_after_busy", {31'd0, busy}, 32'd0);
    bus_read(11'h103, 8'd16, "rp_plen");
`else
    bus_write(11'h102, 8'hFF);
    chk("nt_pulse_out", {24'd0, out_bits}, 32'h82);
    chk("nt_busy", {31'd0, busy}, 32'd0);
    bus_write(11'h103, 8'h05);
    bus_read(11'h103, 8'h00, "nt_plen");
    chk("nt_busy2", {31'd0, busy}, 32'd0);
`endif

    // reset in the middle of a read access
    bus_write(11'h100, 8'h11);
    @(negedge clkDspIn);
    ab_buf = 11'h100; re_deb = 1'b0;
    @(negedge clkDspIn);
    chk("ra_oe_pre", {31'd0, db_oe}, 32'd1);
    dsp_reset = 1'b0;
    #1;
    chk("ra_oe", {31'd0, db_oe}, 32'd0);
    chk("ra_dbout", {24'd0, db_out}, 32'h00);
    chk("ra_out", {24'd0, out_bits}, 32'h00);
    re_deb = 1'b1;
    @(negedge clkDspIn);
    dsp_reset = 1'b1;
    repeat (3) @(negedge clkDspIn);
    chk("ra_after_oe", {31'd0, db_oe}, 32'd0);
    chk("ra_after_out", {24'd0, out_bits}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dsp_output_sequencer.md
DSP_OUTPUT_SEQUENCER -- requirements
Module: dsp_output_sequencer

Interface
REQ-001 Clock and reset SHALL be: reset dsp_reset, asynchronous, active-low; clock clkDspIn.
REQ-002 Parameter BASE_ADDR, default 11'h100, is the base of the 4-register window on ab_buf.
REQ-003 Ports SHALL be:
  clkDspIn   in   1   DSP bus clock
  dsp_reset  in   1   async active-low reset
  we_deb     in   1   debounced write strobe, active-low
  re_deb     in   1   debounced read strobe, active-low
  ab_buf     in   11  DSP address bits [18:8]
  db_in      in   8   write data, low byte
  out_bits   out  8   channel outputs, registered
  busy       out  1   pulse sequence in progress
  db_out     out  8   readback data, registered
  db_oe      out  1   readback drive enable, registered

Function
REQ-004 Register map (offset from BASE_ADDR): +0 SET (write, readback out_bits); +1 CLR (write); +2 PULSE (write mask); +3 PULSE_LEN (read/write); other addresses SHALL have no effect.
REQ-005 Bus FSM SHALL have the states IDLE, WR_HOLD and RD_HOLD.
REQ-006 IDLE->WR_HOLD when we_deb is sampled low with a matching address; one write action SHALL execute on that edge only.
REQ-007 IDLE->RD_HOLD when re_deb is sampled low (we_deb high) with a matching address.
REQ-008 WR_HOLD/RD_HOLD->IDLE when the respective strobe is sampled high; a held strobe SHALL never retrigger an action.
REQ-009 Both strobes sampled low in IDLE: the write SHALL take priority; the read SHALL be ignored for that access.
REQ-010 SET write: out_bits <= out_bits | db_in, visible one clock after the strobe is sampled.
REQ-011 CLR write: out_bits <= out_bits & ~db_in, with the same latency.
REQ-012 Read: db_out SHALL be loaded on entry to RD_HOLD; db_oe SHALL be high throughout RD_HOLD and low otherwise.
REQ-013 PULSE write while busy=0: mask bits SHALL be set in out_bits, counter <= pulse_len, busy <= 1.
REQ-014 While busy, the counter SHALL decrement each clock; on the clock it reaches 0, mask bits SHALL clear and busy SHALL drop, so bits are high for exactly pulse_len clocks.
REQ-015 PULSE_LEN is 8 bits; a write of 0 SHALL store 1.
REQ-016 PULSE write while busy=1 SHALL be ignored; PULSE_LEN write while busy SHALL apply to the next pulse only.
REQ-017 PULSE write with mask 0 SHALL still run the timer (busy for pulse_len clocks).
REQ-018 SET/CLR during a pulse SHALL apply immediately; a pulse end coinciding with a SET/CLR write SHALL apply the pulse clear first, then the bus write (bus wins per bit).

Reset
REQ-019 Asserted reset SHALL force out_bits=0, busy=0, db_out=0, db_oe=0, counter=0, pulse_len=8'd16, FSMs to IDLE.
REQ-020 Reset mid-pulse or mid-access SHALL abort with no residual action after release.

Configuration
REQ-021 Macro DSP_OUT_PULSE_TIMER_EN: when defined, REQ-013..REQ-018 SHALL be implemented as specified.
REQ-022 When undefined: PULSE/PULSE_LEN accesses SHALL be no-ops, PULSE_LEN SHALL read 0, busy SHALL be tied 0, and no counter logic SHALL be present.

Structure
REQ-023 Package dsp_out_seq_pkg SHALL hold the register offsets, CH_W=8, the pulse_len reset value and the bus-FSM state encoding.
REQ-024 Sub-module dsp_out_pulse_timer SHALL implement the counter/busy logic (inputs start, len; outputs busy, done) and SHALL be instantiated only under DSP_OUT_PULSE_TIMER_EN.

Verification
REQ-025 SET 8'h05, then CLR 8'h04 -> out_bits=8'h05 one clock after the first strobe, then 8'h01.
REQ-026 we_deb held low 20 clocks at SET with db_in=8'h80, with a CLR of 8'h80 issued between strobes -> one action per strobe; final out_bits=8'h00.
REQ-027 PULSE_LEN=3, PULSE mask 8'h30 -> out_bits[5:4] high exactly 3 clocks, busy high for the same 3 clocks; second PULSE during busy -> ignored.
REQ-028 Both strobes low at +0 with db_in=8'h02 -> out_bits bit1 set, db_oe stays 0.
REQ-029 dsp_reset asserted at pulse clock 2 of a 16-clock pulse -> all outputs 0 immediately; after release, PULSE_LEN reads 8'd16.
REQ-030 Build without DSP_OUT_PULSE_TIMER_EN: PULSE 8'hFF -> out_bits unchanged; PULSE_LEN reads 8'h00; busy=0.
